// File: rtl/instr_buffer_pkg.sv
// Shared core configuration and instruction-buffer entry type.
// Provides FETCH_WIDTH, DECODE_WIDTH, INSTR_BUFFER_SIZE and instr_info_t.
package instr_buffer_pkg;

    localparam int FETCH_WIDTH       = 4;
    localparam int DECODE_WIDTH      = 2;
    localparam int INSTR_BUFFER_SIZE = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } instr_info_t;

endpackage

// File: rtl/instr_compactor.sv
// Packs valid fetch lanes densely in lane order and counts them.
// Ports: lanes (in, FETCH_WIDTH entries), slots (out, dense), n_push (out).
module instr_compactor
    import instr_buffer_pkg::*;
(
    input  instr_info_t lanes  [FETCH_WIDTH],
    output instr_info_t slots  [FETCH_WIDTH],
    output logic [$clog2(FETCH_WIDTH+1)-1:0] n_push
);

    localparam int PUSH_W = $clog2(FETCH_WIDTH + 1);
    localparam int SLOT_W = $clog2(FETCH_WIDTH);

    logic [PUSH_W-1:0] n;

    // n is the running prefix popcount: the k-th valid lane lands in slot k.
    always_comb begin
        n = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            slots[k] = '0;
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (lanes[i].valid) begin
                slots[n[SLOT_W-1:0]] = lanes[i];
                n = n + 1'b1;
            end
        end
        n_push = n;
    end

endmodule

// File: rtl/instr_buffer.sv
// Circular instruction queue between the IFU and decode.
// Ports: clk, rst_n, frontend_instr_i, frontend_stallreq_o, backend_flush_i,
//        decode_accept_i, decode_instr_o (lane 0 oldest).
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int IB_DEPTH = INSTR_BUFFER_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  instr_info_t             frontend_instr_i [FETCH_WIDTH],
    output logic                    frontend_stallreq_o,
    input  logic                    backend_flush_i,
    input  logic [DECODE_WIDTH-1:0] decode_accept_i,
    output instr_info_t             decode_instr_o [DECODE_WIDTH]
);

    localparam int PTR_W  = $clog2(IB_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PUSH_W = $clog2(FETCH_WIDTH + 1);
    localparam int POP_W  = $clog2(DECODE_WIDTH + 1);

    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;
    instr_info_t             mem   [IB_DEPTH];
    instr_info_t             slots [FETCH_WIDTH];
    logic [PUSH_W-1:0]       n_push;
    logic [POP_W-1:0]        n_pop;
    logic [DECODE_WIDTH-1:0] out_valid;
    logic                    run;

    instr_compactor u_compactor (
        .lanes  (frontend_instr_i),
        .slots  (slots),
        .n_push (n_push)
    );

    // Registered count only, so the frontend sees no input-to-stall path.
    assign frontend_stallreq_o =
        (CNT_W'(IB_DEPTH) - count) < CNT_W'(FETCH_WIDTH);

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            out_valid[i] = !backend_flush_i && (CNT_W'(i) < count);
            decode_instr_o[i]       = mem[head + PTR_W'(i)];
            decode_instr_o[i].valid = out_valid[i];
        end
    end

    // Only the leading run of accepted valid lanes pops; a gap ends it.
    always_comb begin
        n_pop = '0;
        run   = 1'b1;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            run = run & decode_accept_i[i] & out_valid[i];
            if (run) begin
                n_pop = n_pop + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!backend_flush_i) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (PUSH_W'(k) < n_push) begin
                    mem[tail + PTR_W'(k)] <= slots[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (backend_flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_pop);
            tail  <= tail + PTR_W'(n_push);
            count <= count + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed self-checking bench for instr_buffer.
// Each task drives one scenario and checks hand-computed results inline.
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    instr_info_t             fe  [FETCH_WIDTH];
    logic                    stall;
    logic                    flush = 1'b0;
    logic [DECODE_WIDTH-1:0] acc = '0;
    instr_info_t             dec [DECODE_WIDTH];

    int chk  = 0;
    int errs = 0;
    int seq  = 0;

    instr_buffer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .frontend_instr_i    (fe),
        .frontend_stallreq_o (stall),
        .backend_flush_i     (flush),
        .decode_accept_i     (acc),
        .decode_instr_o      (dec)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pc_of(input int n);
        return 32'h1c00_0000 + 32'(n * 4);
    endfunction

    // Illegal conditions: overflowing push, count beyond depth.
    always @(negedge clk) begin
        int np;
        np = 0;
        for (int i = 0; i < FETCH_WIDTH; i++) np += int'(fe[i].valid);
        if (rst_n && !flush && np > 16 - int'(dut.count)) begin
            errs++;
            $display("FAIL overflow_push n_push %0d free %0d", np, 16 - int'(dut.count));
        end
        if (int'(dut.count) > 16) begin
            errs++;
            $display("FAIL count_range got %0d want <=16", dut.count);
        end
    end

    task automatic clear_in();
        for (int i = 0; i < FETCH_WIDTH; i++) fe[i] = '0;
        acc   = '0;
        flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            fe[i].valid = 1'b1;
            fe[i].pc    = pc_of(seq);
            fe[i].instr = 32'h0000_0013 + 32'(seq);
            seq++;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        #3;
        chk++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %0b want 0", stall); end
        chk++; if (dec[0].valid !== 1'b0) begin errs++; $display("FAIL reset_v0 got %0b want 0", dec[0].valid); end
        chk++; if (dec[1].valid !== 1'b0) begin errs++; $display("FAIL reset_v1 got %0b want 0", dec[1].valid); end
        chk++; if (dut.count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d want 0", dut.count); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_push_four();
        seq = 0;
        load(4);
        #1;
        chk++; if (dec[0].valid !== 1'b0) begin errs++; $display("FAIL no_bypass got %0b want 0", dec[0].valid); end
        tick();
        chk++; if (dut.count !== 5'd4) begin errs++; $display("FAIL push4_count got %0d want 4", dut.count); end
        chk++; if (dec[0].valid !== 1'b1 || dec[0].pc !== 32'h1c00_0000) begin errs++; $display("FAIL push4_lane0 got %0b/%h want 1/1c000000", dec[0].valid, dec[0].pc); end
        chk++; if (dec[1].valid !== 1'b1 || dec[1].pc !== 32'h1c00_0004) begin errs++; $display("FAIL push4_lane1 got %0b/%h want 1/1c000004", dec[1].valid, dec[1].pc); end
        chk++; if (stall !== 1'b0) begin errs++; $display("FAIL push4_stall got %0b want 0", stall); end
        acc = 2'b11;
        tick();
        chk++; if (dut.count !== 5'd2) begin errs++; $display("FAIL pop2_count got %0d want 2", dut.count); end
        chk++; if (dec[0].pc !== 32'h1c00_0008) begin errs++; $display("FAIL pop2_lane0 got %h want 1c000008", dec[0].pc); end
        acc = 2'b11;
        tick();
        chk++; if (dut.count !== 5'd0 || dec[0].valid !== 1'b0) begin errs++; $display("FAIL drain got %0d/%0b want 0/0", dut.count, dec[0].valid); end
    endtask

    task automatic test_sparse();
        do_flush();
        fe[1] = '{valid: 1'b1, pc: 32'h2000_0010, instr: 32'h11};
        fe[3] = '{valid: 1'b1, pc: 32'h2000_0030, instr: 32'h33};
        tick();
        chk++; if (dut.count !== 5'd2) begin errs++; $display("FAIL sparse_count got %0d want 2", dut.count); end
        chk++; if (dut.tail !== 4'd2) begin errs++; $display("FAIL sparse_tail got %0d want 2", dut.tail); end
        chk++; if (dut.mem[0].pc !== 32'h2000_0010) begin errs++; $display("FAIL sparse_slot0 got %h want 20000010", dut.mem[0].pc); end
        chk++; if (dut.mem[1].pc !== 32'h2000_0030) begin errs++; $display("FAIL sparse_slot1 got %h want 20000030", dut.mem[1].pc); end
        chk++; if (dec[0].pc !== 32'h2000_0010 || dec[1].pc !== 32'h2000_0030) begin errs++; $display("FAIL sparse_order got %h,%h want 20000010,20000030", dec[0].pc, dec[1].pc); end
    endtask

    task automatic test_stall();
        do_flush();
        seq = 100;
        load(4); tick();
        load(4); tick();
        chk++; if (dut.count !== 5'd8 || stall !== 1'b0) begin errs++; $display("FAIL stall8 got %0d/%0b want 8/0", dut.count, stall); end
        load(4); tick();
        chk++; if (dut.count !== 5'd12 || stall !== 1'b0) begin errs++; $display("FAIL stall12 got %0d/%0b want 12/0", dut.count, stall); end
        load(1); tick();
        chk++; if (dut.count !== 5'd13 || stall !== 1'b1) begin errs++; $display("FAIL stall13 got %0d/%0b want 13/1", dut.count, stall); end
        acc = 2'b01; tick();
        chk++; if (dut.count !== 5'd12 || stall !== 1'b0) begin errs++; $display("FAIL unstall12 got %0d/%0b want 12/0", dut.count, stall); end
        chk++; if (dec[0].pc !== pc_of(101)) begin errs++; $display("FAIL unstall12_pc got %h want %h", dec[0].pc, pc_of(101)); end
        acc = 2'b11; tick();
        chk++; if (dut.count !== 5'd10 || dec[0].pc !== pc_of(103)) begin errs++; $display("FAIL pop10 got %0d/%h want 10/%h", dut.count, dec[0].pc, pc_of(103)); end
        load(2); tick();
        load(4); acc = 2'b11; tick();
        chk++; if (dut.count !== 5'd14 || stall !== 1'b1) begin errs++; $display("FAIL pushpop14 got %0d/%0b want 14/1", dut.count, stall); end
        chk++; if (dec[0].pc !== pc_of(105) || dec[1].pc !== pc_of(106)) begin errs++; $display("FAIL pushpop14_pc got %h,%h want %h,%h", dec[0].pc, dec[1].pc, pc_of(105), pc_of(106)); end
        for (int i = 0; i < 7; i++) begin
            acc = 2'b11;
            tick();
        end
        chk++; if (dut.count !== 5'd0) begin errs++; $display("FAIL stall_drain got %0d want 0", dut.count); end
    endtask

    task automatic test_in_order();
        do_flush();
        seq = 200;
        load(4); tick();
        load(1); tick();
        acc = 2'b10; tick();
        chk++; if (dut.count !== 5'd5 || dut.head !== 4'd0) begin errs++; $display("FAIL gap_accept got %0d/%0d want 5/0", dut.count, dut.head); end
        acc = 2'b01; tick();
        chk++; if (dut.count !== 5'd4 || dut.head !== 4'd1) begin errs++; $display("FAIL lane0_accept got %0d/%0d want 4/1", dut.count, dut.head); end
        chk++; if (dec[0].pc !== pc_of(201)) begin errs++; $display("FAIL lane0_accept_pc got %h want %h", dec[0].pc, pc_of(201)); end
        acc = 2'b11; tick();
        acc = 2'b11; tick();
    endtask

    task automatic test_wrap();
        do_flush();
        seq = 300;
        for (int i = 0; i < 3; i++) begin
            load(4);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            acc = 2'b11;
            tick();
        end
        load(2); tick();
        chk++; if (dut.head !== 4'd12 || dut.tail !== 4'd14) begin errs++; $display("FAIL wrap_setup got %0d/%0d want 12/14", dut.head, dut.tail); end
        load(4); acc = 2'b11; tick();
        chk++; if (dut.count !== 5'd4 || dut.head !== 4'd14 || dut.tail !== 4'd2) begin errs++; $display("FAIL wrap_ptrs got %0d/%0d/%0d want 4/14/2", dut.count, dut.head, dut.tail); end
        chk++; if (dut.mem[14].pc !== pc_of(314) || dut.mem[15].pc !== pc_of(315)) begin errs++; $display("FAIL wrap_hi got %h,%h want %h,%h", dut.mem[14].pc, dut.mem[15].pc, pc_of(314), pc_of(315)); end
        chk++; if (dut.mem[0].pc !== pc_of(316) || dut.mem[1].pc !== pc_of(317)) begin errs++; $display("FAIL wrap_lo got %h,%h want %h,%h", dut.mem[0].pc, dut.mem[1].pc, pc_of(316), pc_of(317)); end
        chk++; if (dec[0].pc !== pc_of(314) || dec[1].pc !== pc_of(315)) begin errs++; $display("FAIL wrap_out0 got %h,%h want %h,%h", dec[0].pc, dec[1].pc, pc_of(314), pc_of(315)); end
        acc = 2'b11; tick();
        chk++; if (dut.count !== 5'd2 || dec[0].pc !== pc_of(316) || dec[1].pc !== pc_of(317)) begin errs++; $display("FAIL wrap_out1 got %0d/%h,%h want 2/%h,%h", dut.count, dec[0].pc, dec[1].pc, pc_of(316), pc_of(317)); end
        acc = 2'b11; tick();
    endtask

    task automatic test_flush();
        do_flush();
        seq = 400;
        load(4); tick();
        load(4); tick();
        load(1); tick();
        chk++; if (dut.count !== 5'd9) begin errs++; $display("FAIL flush_pre got %0d want 9", dut.count); end
        load(4);
        flush = 1'b1;
        acc   = 2'b11;
        #1;
        chk++; if (dec[0].valid !== 1'b0 || dec[1].valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %0b%0b want 00", dec[1].valid, dec[0].valid); end
        tick();
        chk++; if (dut.count !== 5'd0 || dut.head !== 4'd0 || dut.tail !== 4'd0) begin errs++; $display("FAIL flush_state got %0d/%0d/%0d want 0/0/0", dut.count, dut.head, dut.tail); end
        seq = 500;
        load(1); tick();
        chk++; if (dut.mem[0].pc !== pc_of(500) || dec[0].pc !== pc_of(500) || dut.count !== 5'd1) begin errs++; $display("FAIL flush_restart got %h/%h/%0d want %h/%h/1", dut.mem[0].pc, dec[0].pc, dut.count, pc_of(500), pc_of(500)); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            load(4);
            tick();
        end
        chk++; if (stall !== 1'b1) begin errs++; $display("FAIL mid_pre_stall got %0b want 1", stall); end
        #2;
        rst_n = 1'b0;
        #1;
        chk++; if (stall !== 1'b0) begin errs++; $display("FAIL mid_reset_stall got %0b want 0", stall); end
        chk++; if (dec[0].valid !== 1'b0 || dec[1].valid !== 1'b0) begin errs++; $display("FAIL mid_reset_valid got %0b%0b want 00", dec[1].valid, dec[0].valid); end
        chk++; if (dut.count !== 5'd0 || dut.head !== 4'd0 || dut.tail !== 4'd0) begin errs++; $display("FAIL mid_reset_state got %0d/%0d/%0d want 0/0/0", dut.count, dut.head, dut.tail); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk++; if (dec[0].valid !== 1'b0) begin errs++; $display("FAIL post_reset_valid got %0b want 0", dec[0].valid); end
    endtask

    initial begin
        test_reset();
        test_push_four();
        test_sparse();
        test_stall();
        test_in_order();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, errs);
        $finish;
    end

endmodule
